// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the D-stage branch controller: instruction type codes,
// FSM state encoding and the default stall limit.
package branch_ctrl_pkg;

    localparam logic [9:0] BEQ     = 10'd4;
    localparam logic [9:0] BSVEALL = 10'd20;

    localparam int unsigned MAX_STALL_DEFAULT = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStall = 2'd1,
        StSlot  = 2'd2
    } br_state_e;

endpackage

// File: rtl/branch_ctrl_hazard.sv
// Combinational RAW hazard detect for a D-stage branch (Tuse = 0) against
// the E and M stage destinations.
module br_hazard (
    input  logic [4:0] d_rs_i,
    input  logic [4:0] d_rt_i,
    input  logic [4:0] e_a3_i,
    input  logic [4:0] m_a3_i,
    input  logic [1:0] e_tnew_i,
    input  logic [1:0] m_tnew_i,
    output logic       hazard_o
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit = (d_rs_i != 5'd0) &&
                 (((d_rs_i == e_a3_i) && (e_tnew_i != 2'd0)) ||
                  ((d_rs_i == m_a3_i) && (m_tnew_i != 2'd0)));
        rt_hit = (d_rt_i != 5'd0) &&
                 (((d_rt_i == e_a3_i) && (e_tnew_i != 2'd0)) ||
                  ((d_rt_i == m_a3_i) && (m_tnew_i != 2'd0)));
        hazard_o = rs_hit || rt_hit;
    end

endmodule

// File: rtl/branch_ctrl.sv
// D-stage branch controller: stalls branches on operand hazards, commits the
// CMP decision to next-PC selection, polices the delay slot and counts branches.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_STALL = MAX_STALL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  D_inStrType,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [4:0]  E_A3,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [1:0]  M_Tnew,
    input  logic        cmp_isBranch,
    input  logic        cmp_flush,
    output logic        stall,
    output logic        npc_sel,
    output logic        flush_FD,
    output logic        slot_err,
    output logic        stall_err,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
);

    br_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        flushed_q, flushed_d;
    logic        stall_err_q, stall_err_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    logic is_br;
    logic hazard;

    br_hazard u_br_hazard (
        .d_rs_i   (D_rs),
        .d_rt_i   (D_rt),
        .e_a3_i   (E_A3),
        .m_a3_i   (M_A3),
        .e_tnew_i (E_Tnew),
        .m_tnew_i (M_Tnew),
        .hazard_o (hazard)
    );

    assign is_br = (D_inStrType == BEQ) || (D_inStrType == BSVEALL);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flushed_d   = 1'b0;
        stall_err_d = stall_err_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        stall       = 1'b0;
        npc_sel     = 1'b0;
        flush_FD    = 1'b0;
        slot_err    = 1'b0;

        unique case (state_q)
            StIdle, StStall: begin
                if (!is_br) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else if (hazard) begin
                    // CMP outputs are not trusted while operands are still in flight.
                    stall   = 1'b1;
                    state_d = StStall;
                    if (state_q == StIdle) begin
                        cnt_d = 3'd1;
                    end else if (cnt_q != 3'd7) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                    if (32'(cnt_d) >= MAX_STALL + 1) begin
                        stall_err_d = 1'b1;
                    end
                end else begin
                    npc_sel   = cmp_isBranch;
                    flush_FD  = cmp_flush;
                    flushed_d = cmp_flush;
                    br_cnt_d  = br_cnt_q + 32'd1;
                    if (cmp_isBranch) begin
                        taken_cnt_d = taken_cnt_q + 32'd1;
                    end
                    cnt_d   = 3'd0;
                    state_d = StSlot;
                end
            end
            StSlot: begin
                // An annulled slot holds a bubble, whatever the type field shows.
                state_d = StIdle;
                if (!flushed_q && is_br) begin
                    slot_err = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            flushed_q   <= 1'b0;
            stall_err_q <= 1'b0;
            br_cnt_q    <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flushed_q   <= flushed_d;
            stall_err_q <= stall_err_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign stall_err = stall_err_q;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Vector bench for branch_ctrl: each row gives one cycle of stimulus, the expected
// combinational controls in that cycle and the expected registered state after its edge.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    localparam logic [9:0] NOP = 10'd1;

    typedef struct {
        logic        rst;
        logic [9:0]  ty;
        logic [4:0]  rs, rt, ea3, ma3;
        logic [1:0]  et, mt;
        logic        isb, fl;
        logic        c;
        logic        st, npc, ffd, serr;
        logic [31:0] br, tk;
        logic        se;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  D_inStrType = '0;
    logic [4:0]  D_rs = '0, D_rt = '0, E_A3 = '0, M_A3 = '0;
    logic [1:0]  E_Tnew = '0, M_Tnew = '0;
    logic        cmp_isBranch = 1'b0, cmp_flush = 1'b0;
    logic        stall, npc_sel, flush_FD, slot_err, stall_err;
    logic [31:0] br_cnt, taken_cnt;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    vec_t sb[$];

    branch_ctrl #(.MAX_STALL(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .D_inStrType  (D_inStrType),
        .D_rs         (D_rs),
        .D_rt         (D_rt),
        .E_A3         (E_A3),
        .M_A3         (M_A3),
        .E_Tnew       (E_Tnew),
        .M_Tnew       (M_Tnew),
        .cmp_isBranch (cmp_isBranch),
        .cmp_flush    (cmp_flush),
        .stall        (stall),
        .npc_sel      (npc_sel),
        .flush_FD     (flush_FD),
        .slot_err     (slot_err),
        .stall_err    (stall_err),
        .br_cnt       (br_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int rst, logic [9:0] ty, int rs, int rt, int ea3, int et,
                                int ma3, int mt, int isb, int fl, int c, int st, int npc,
                                int ffd, int serr, int br, int tk, int se);
        vec_t v;
        v.rst = rst[0];  v.ty = ty;
        v.rs = rs[4:0];  v.rt = rt[4:0];  v.ea3 = ea3[4:0];  v.ma3 = ma3[4:0];
        v.et = et[1:0];  v.mt = mt[1:0];  v.isb = isb[0];    v.fl = fl[0];
        v.c = c[0];      v.st = st[0];    v.npc = npc[0];    v.ffd = ffd[0];
        v.serr = serr[0];
        v.br = br;       v.tk = tk;       v.se = se[0];
        return v;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        //             rst ty       rs rt ea3 et ma3 mt isb fl  c st npc ffd serr br tk se
        tbl.push_back(mk(1, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0));
        // taken beq, no hazard, then ordinary slot
        tbl.push_back(mk(0, BEQ,     5, 5, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0,  1, 1, 0));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 0));
        // bsveall stalled two cycles on E, then untaken with annul
        tbl.push_back(mk(0, BSVEALL, 3, 0, 3, 2, 0, 0, 0, 1,  1, 1, 0, 0, 0,  1, 1, 0));
        tbl.push_back(mk(0, BSVEALL, 3, 0, 3, 2, 0, 0, 0, 1,  1, 1, 0, 0, 0,  1, 1, 0));
        tbl.push_back(mk(0, BSVEALL, 3, 0, 3, 0, 0, 0, 0, 1,  1, 0, 0, 1, 0,  2, 1, 0));
        // annulled slot is a bubble even with a branch code
        tbl.push_back(mk(0, BEQ,     5, 5, 0, 0, 0, 0, 1, 1,  1, 0, 0, 0, 0,  2, 1, 0));
        // taken beq then beq in delay slot
        tbl.push_back(mk(0, BEQ,     5, 5, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0,  3, 2, 0));
        tbl.push_back(mk(0, BEQ,     5, 5, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 1,  3, 2, 0));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  3, 2, 0));
        // M hazard on rt held 5 cycles, CMP inputs asserted but ignored
        tbl.push_back(mk(0, BEQ,     1, 7, 0, 0, 7, 1, 1, 1,  1, 1, 0, 0, 0,  3, 2, 0));
        tbl.push_back(mk(0, BEQ,     1, 7, 0, 0, 7, 1, 1, 1,  1, 1, 0, 0, 0,  3, 2, 0));
        tbl.push_back(mk(0, BEQ,     1, 7, 0, 0, 7, 1, 1, 1,  1, 1, 0, 0, 0,  3, 2, 0));
        tbl.push_back(mk(0, BEQ,     1, 7, 0, 0, 7, 1, 1, 1,  1, 1, 0, 0, 0,  3, 2, 1));
        tbl.push_back(mk(0, BEQ,     1, 7, 0, 0, 7, 1, 1, 1,  1, 1, 0, 0, 0,  3, 2, 1));
        tbl.push_back(mk(0, BEQ,     1, 7, 0, 0, 7, 0, 0, 0,  1, 0, 0, 0, 0,  4, 2, 1));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  4, 2, 1));
        tbl.push_back(mk(1, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));
        // r0 never hazards
        tbl.push_back(mk(0, BEQ,     0, 0, 0, 2, 0, 0, 1, 0,  1, 0, 1, 0, 0,  1, 1, 0));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 0));
        // reset during the 2nd stall cycle
        tbl.push_back(mk(0, BSVEALL, 9, 0, 9, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  1, 1, 0));
        tbl.push_back(mk(1, BSVEALL, 9, 0, 9, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0));
        // stall count restarts from 1 after reset
        tbl.push_back(mk(0, BEQ,     9, 0, 9, 1, 0, 0, 1, 1,  1, 1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, BEQ,     9, 0, 9, 1, 0, 0, 1, 1,  1, 1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, BEQ,     9, 0, 9, 1, 0, 0, 1, 1,  1, 1, 0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, BEQ,     9, 0, 9, 1, 0, 0, 1, 1,  1, 1, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(1, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0));
        // taken bsveall without annul
        tbl.push_back(mk(0, BSVEALL, 2, 3, 0, 0, 0, 0, 1, 0,  1, 0, 1, 0, 0,  1, 1, 0));
        tbl.push_back(mk(0, NOP,     0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset        = tbl[i].rst;
            D_inStrType  = tbl[i].ty;
            D_rs         = tbl[i].rs;
            D_rt         = tbl[i].rt;
            E_A3         = tbl[i].ea3;
            E_Tnew       = tbl[i].et;
            M_A3         = tbl[i].ma3;
            M_Tnew       = tbl[i].mt;
            cmp_isBranch = tbl[i].isb;
            cmp_flush    = tbl[i].fl;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            if (e.c) begin
                chk("stall",    i, 32'(stall),    32'(e.st));
                chk("npc_sel",  i, 32'(npc_sel),  32'(e.npc));
                chk("flush_FD", i, 32'(flush_FD), 32'(e.ffd));
                chk("slot_err", i, 32'(slot_err), 32'(e.serr));
            end
            @(posedge clk);
            #1;
            chk("br_cnt",    i, br_cnt,            e.br);
            chk("taken_cnt", i, taken_cnt,         e.tk);
            chk("stall_err", i, 32'(stall_err),    32'(e.se));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Decode-stage branch controller for the P5 pipeline. It sequences the D-stage comparator (CMP): it stalls a branch until its operands are forwardable, then commits the CMP decision to next-PC selection. It annuls the delay slot of an untaken `bsveall` and polices the delay-slot cycle. It sits between the hazard inputs from E/M, the CMP outputs, and the PC/F-D register controls, and keeps branch performance counters.

## Interface
- MAX_STALL, 3: consecutive stall cycles allowed before `stall_err` is raised.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- D_inStrType  in  10  D-stage instruction type code (shared InStrType encodings).
- D_rs, D_rt  in  5 each  D-stage source register numbers.
- E_A3, M_A3  in  5 each  destination register of the E and M stage instructions.
- E_Tnew, M_Tnew  in  2 each  cycles until E/M result is forwardable.
- cmp_isBranch  in  1  CMP taken decision.
- cmp_flush  in  1  CMP likely-annul request.
- stall  out  1  freeze PC and F/D, insert bubble into D/E.
- npc_sel  out  1  1 = next PC is branch target.
- flush_FD  out  1  clear F/D at the coming edge (annul delay slot).
- slot_err  out  1  one-cycle pulse: branch found in a delay slot.
- stall_err  out  1  sticky until reset: stall exceeded MAX_STALL.
- br_cnt  out  32  resolved branches, wraps.
- taken_cnt  out  32  taken branches, wraps.

## Operation
- A branch is D_inStrType equal to `beq` or `bsveall`. All other codes are non-branch.
- Hazard: `(D_rs!=0 && D_rs==E_A3 && E_Tnew>0) || (D_rs!=0 && D_rs==M_A3 && M_Tnew>0)`, with the same test for D_rt. Branch Tuse is 0.
- FSM states: IDLE, STALL, SLOT.
- IDLE, branch with hazard:
  - stall=1, npc_sel=0, flush_FD=0.
  - Next state STALL; stall counter is set to 1.
- IDLE, branch without hazard (resolve):
  - npc_sel=cmp_isBranch; flush_FD=cmp_flush.
  - br_cnt +1; taken_cnt +1 if taken.
  - Next state SLOT.
- IDLE, non-branch: all control outputs 0; state stays IDLE.
- STALL, hazard still present:
  - stall=1; counter +1, saturating at 7.
  - When the counter reaches MAX_STALL+1, stall_err sets.
- STALL, hazard cleared: resolve exactly as in IDLE, then go to SLOT.
- SLOT (delay-slot instruction is in D):
  - If flush_FD was asserted, D holds a bubble. Treat it as non-branch and return to IDLE.
  - Otherwise, if D_inStrType is a branch: slot_err=1 for this cycle, npc_sel=0, flush_FD=0, no counting. The instruction is executed as a nop-branch.
  - Otherwise behave as IDLE for hazards/resolution, but a branch in SLOT is always the error case.
- Priority:
  - stall forces npc_sel=0 and flush_FD=0.
  - CMP inputs are ignored whenever stall=1.
- Counters: 32-bit, modulo 2^32, with no saturation.

## Timing
- Reset values: state IDLE, stall 0, npc_sel 0, flush_FD 0, slot_err 0, stall_err 0, br_cnt 0, taken_cnt 0, stall counter 0.
- stall, npc_sel and flush_FD are combinational from state plus current inputs. They are valid in the same cycle as D_inStrType.
- State, counters and stall_err update on the rising edge.
- Resolution latency: 0 cycles without a hazard; N cycles with N stall cycles.
- The counter increment is visible at the edge ending the resolve cycle.
- Reset asserted mid-STALL or in SLOT returns to IDLE at that edge. The pending branch is not counted.
- Reset overrides all other events in the same cycle.

## Structure
- Shared package (the existing InStrType include): `beq` and `bsveall` codes, FSM state encodings (2 bits), and the MAX_STALL default.
- One sub-module, `br_hazard`: purely combinational hazard detect from D_rs/D_rt and E/M A3/Tnew.
- The FSM, counters and output muxing live in branch_ctrl.

## Test plan
- `beq` with rs=rt=5, no hazard, cmp_isBranch=1 → npc_sel=1 same cycle, br_cnt=1, taken_cnt=1 next edge, state SLOT.
- `bsveall` with E_A3=rs=3, E_Tnew=2 for 2 cycles, then cleared; cmp_isBranch=0, cmp_flush=1 → stall=1 for 2 cycles, then flush_FD=1, npc_sel=0, br_cnt=1, taken_cnt=0.
- Hazard held for 4 cycles with MAX_STALL=3 → stall_err=1 after the 4th stall edge, and it stays 1 until reset.
- Taken `beq` followed by a `beq` in the delay slot → slot_err pulse of 1 cycle, npc_sel=0, br_cnt stays 1.
- Reset asserted during the 2nd stall cycle → next edge: state IDLE, stall=0, counters 0, no count for the aborted branch.
- rs=0 matching E_A3=0 with E_Tnew=2 → no stall; resolve immediately.
